// File: rtl/rr_sched_pkg.sv
// Shared definitions for the round-robin grant scheduler: the FSM state
// encoding and the width helper for the optional tenure hold counter.
package rr_sched_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

  // Hold counter must count 0 .. hold_max-1; never narrower than one bit.
  function automatic int hold_cnt_w(input int hold_max);
    return (hold_max <= 2) ? 1 : $clog2(hold_max);
  endfunction

endpackage

// File: rtl/rr_grant_sched_dec.sv
// Binary-to-one-hot decoder with enable. Output is all zero when en = 0.
module rr_grant_sched_dec #(
  parameter  int IP_WIDTH = 2,
  localparam int OP_WIDTH = 1 << IP_WIDTH
) (
  input  logic                en,
  input  logic [IP_WIDTH-1:0] i,
  output logic [OP_WIDTH-1:0] y
);

  // Drive exactly the bit selected by i when enabled.
  always_comb begin
    y = '0;
    for (int k = 0; k < OP_WIDTH; k++) begin
      if (en && (i == k[IP_WIDTH-1:0])) begin
        y[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_grant_sched.sv
// Round-robin scheduler sharing one resource among 2^IP_WIDTH requesters.
// A grant is held until the owner pulses done or drops its request; one
// idle cycle always separates consecutive tenures.
// Optional build macro RR_SCHED_TIMEOUT_EN bounds each tenure to HOLD_MAX
// cycles and pulses timeout on a forced release.
module rr_grant_sched
  import rr_sched_pkg::*;
#(
  parameter  int IP_WIDTH = 2,
  parameter  int HOLD_MAX = 16,
  localparam int OP_WIDTH = 1 << IP_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OP_WIDTH-1:0] req,
  input  logic                done,
  output logic                gnt_vld,
  output logic [IP_WIDTH-1:0] gnt_idx,
  output logic [OP_WIDTH-1:0] gnt,
  output logic                timeout
);

  localparam int HOLD_W = hold_cnt_w(HOLD_MAX);

  state_e              state_q, state_d;
  logic [IP_WIDTH-1:0] ptr_q, ptr_d;
  logic [IP_WIDTH-1:0] gnt_idx_q, gnt_idx_d;
  logic                gnt_vld_q, gnt_vld_d;

  logic [2*OP_WIDTH-1:0] req_dbl;
  logic [OP_WIDTH-1:0]   req_rot;
  logic [IP_WIDTH-1:0]   first_rot;
  logic [IP_WIDTH-1:0]   winner;
  logic                  rel;
  logic                  force_rel;

  // Priority search from ptr: rotate so ptr sits at bit 0, pick the lowest
  // set bit, then add ptr back (wraps naturally modulo N).
  always_comb begin
    req_dbl   = {req, req} >> ptr_q;
    req_rot   = req_dbl[OP_WIDTH-1:0];
    first_rot = '0;
    for (int k = OP_WIDTH - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        first_rot = k[IP_WIDTH-1:0];
      end
    end
    winner = first_rot + ptr_q;
  end

  // Owner gives up the resource by pulsing done or dropping its request.
  assign rel = (state_q == ST_OWN) && (done || !req[gnt_idx_q]);

`ifdef RR_SCHED_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_q, hold_d;

  // Hold counter sits at zero while idle, so each tenure starts from zero.
  always_comb begin
    hold_d = '0;
    if (state_q == ST_OWN) begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  // Hold counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  // A normal release in the final cycle wins over the forced one.
  assign force_rel = (state_q == ST_OWN) && !rel &&
                     (hold_q == HOLD_W'(HOLD_MAX - 1));
`else
  logic unused_hold_cfg;
  assign unused_hold_cfg = ^HOLD_W;
  assign force_rel       = 1'b0;
`endif

  // Next-state logic: grant from IDLE, release from OWN.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_idx_d = gnt_idx_q;
    gnt_vld_d = gnt_vld_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d   = ST_OWN;
          gnt_idx_d = winner;
          gnt_vld_d = 1'b1;
        end
      end
      ST_OWN: begin
        if (rel || force_rel) begin
          state_d   = ST_IDLE;
          gnt_vld_d = 1'b0;
          ptr_d     = gnt_idx_q + IP_WIDTH'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        gnt_vld_d = 1'b0;
      end
    endcase
  end

  // State, pointer and registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
      gnt_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_vld_q <= gnt_vld_d;
    end
  end

  assign gnt_vld = gnt_vld_q;
  assign gnt_idx = gnt_idx_q;
  assign timeout = force_rel;

  rr_grant_sched_dec #(
    .IP_WIDTH(IP_WIDTH)
  ) u_dec (
    .en(gnt_vld_q),
    .i (gnt_idx_q),
    .y (gnt)
  );

endmodule

// File: tb/tb_rr_grant_sched.sv
// Directed bench for rr_grant_sched (IP_WIDTH = 2, HOLD_MAX = 4).
// Expected owners are queued when a request pattern is driven and popped
// when the grant appears one edge later.
module tb_rr_grant_sched;

  localparam int IPW = 2;
  localparam int N   = 1 << IPW;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic           done;
  logic           gnt_vld;
  logic [IPW-1:0] gnt_idx;
  logic [N-1:0]   gnt;
  logic           timeout;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  rr_grant_sched #(
    .IP_WIDTH(IPW),
    .HOLD_MAX(4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .done   (done),
    .gnt_vld(gnt_vld),
    .gnt_idx(gnt_idx),
    .gnt    (gnt),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One edge after the request pattern: the queued owner must hold the grant.
  task automatic expect_grant(input string tag);
    int e;
    logic [N-1:0] oh;
    tick();
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty, got idx %0h", tag, gnt_idx);
    end else begin
      e  = exp_q.pop_front();
      oh = '0;
      oh[e] = 1'b1;
      chk({tag, "_vld"}, 32'(gnt_vld), 32'd1);
      chk({tag, "_idx"}, 32'(gnt_idx), 32'(e));
      chk({tag, "_gnt"}, 32'(gnt), 32'(oh));
    end
  endtask

  // Pulse done for one cycle; the grant must drop on that edge.
  task automatic release_done(input string tag);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk({tag, "_gap_vld"}, 32'(gnt_vld), 32'd0);
    chk({tag, "_gap_gnt"}, 32'(gnt), 32'd0);
  endtask

  initial begin
    // Reset with every requester active.
    rst_n = 1'b0;
    req   = 4'b1111;
    done  = 1'b0;
    #2;
    chk("rst_vld", 32'(gnt_vld), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    tick();
    tick();
    chk("rst_hold_vld", 32'(gnt_vld), 32'd0);
    req   = '0;
    rst_n = 1'b1;
    tick();
    chk("idle_vld", 32'(gnt_vld), 32'd0);

    // Single requester 2, then release with done (ptr -> 3).
    req = 4'b0100;
    exp_q.push_back(2);
    expect_grant("single");
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = '0;
    chk("single_rel_vld", 32'(gnt_vld), 32'd0);
    chk("single_rel_gnt", 32'(gnt), 32'd0);
    chk("idx_hold_idle", 32'(gnt_idx), 32'd2);

    // Wrap from ptr 3 to requester 0, then skip to 1 and 3.
    req = 4'b0011;
    exp_q.push_back(0);
    expect_grant("wrap0");
    release_done("wrap0");
    req = 4'b1010;
    exp_q.push_back(1);
    expect_grant("skip1");
    release_done("skip1");
    exp_q.push_back(3);
    expect_grant("skip3");
    release_done("skip3");
    req = '0;
    tick();

    // Full rotation with all requests held (ptr = 0).
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(k % N);
      expect_grant($sformatf("rot%0d", k));
      release_done($sformatf("rot%0d", k));
    end
    req = '0;
    tick();

    // Owner 1 keeps the grant while requester 0 asks; dropping req[1] releases.
    req = 4'b1111;
    exp_q.push_back(1);
    expect_grant("own1");
    tick();
    tick();
    chk("nopreempt_vld", 32'(gnt_vld), 32'd1);
    chk("nopreempt_idx", 32'(gnt_idx), 32'd1);
    req = 4'b1101;
    tick();
    chk("drop_rel_vld", 32'(gnt_vld), 32'd0);
    exp_q.push_back(2);
    expect_grant("after_drop");
    done = 1'b1;
    tick();
    req = '0;
    tick();
    tick();
    done = 1'b0;
    chk("done_idle_vld", 32'(gnt_vld), 32'd0);
    chk("done_idle_gnt", 32'(gnt), 32'd0);

    // done and request drop together count as one release (ptr 3 -> 0).
    req = 4'b1000;
    exp_q.push_back(3);
    expect_grant("own3");
    req  = '0;
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("dual_rel_vld", 32'(gnt_vld), 32'd0);
    req = 4'b0101;
    exp_q.push_back(0);
    expect_grant("single_count");
    req = '0;
    release_done("single_count");
    tick();

    // Long tenure with no release (ptr = 1, only requester 0 asks).
    req = 4'b0001;
    exp_q.push_back(0);
    expect_grant("hold");
    chk("hold_to_c0", 32'(timeout), 32'd0);
`ifdef RR_SCHED_TIMEOUT_EN
    tick();
    chk("hold_to_c1", 32'(timeout), 32'd0);
    tick();
    chk("hold_to_c2", 32'(timeout), 32'd0);
    chk("hold_vld_c2", 32'(gnt_vld), 32'd1);
    tick();
    chk("hold_to_c3", 32'(timeout), 32'd1);
    chk("hold_vld_c3", 32'(gnt_vld), 32'd1);
    tick();
    chk("forced_gap_vld", 32'(gnt_vld), 32'd0);
    chk("forced_gap_to", 32'(timeout), 32'd0);
    exp_q.push_back(0);
    expect_grant("regrant0");
    chk("regrant_to", 32'(timeout), 32'd0);
`else
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("hold_vld", 32'(gnt_vld), 32'd1);
      chk("hold_to", 32'(timeout), 32'd0);
    end
`endif
    req = '0;
    release_done("hold_end");

    // Asynchronous reset in the middle of a tenure (ptr = 1).
    req = 4'b0010;
    exp_q.push_back(1);
    expect_grant("pre_rst");
    #1;
    rst_n = 1'b0;
    req   = 4'b1111;
    #1;
    chk("async_rst_vld", 32'(gnt_vld), 32'd0);
    chk("async_rst_gnt", 32'(gnt), 32'd0);
    chk("async_rst_to", 32'(timeout), 32'd0);
    tick();
    chk("async_rst_hold", 32'(gnt_vld), 32'd0);
    req   = '0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_vld", 32'(gnt_vld), 32'd0);
    req = 4'b1111;
    exp_q.push_back(0);
    expect_grant("post_rst_ptr0");
    req = '0;
    release_done("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
